mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the ARMV4 processor's data-memory bus, downstream of the core.
//  The processor writes bytes to TX_DATA; they are buffered in a FIFO and serialized 8N1 (LSB first) on tx.
//  The processor polls a STATUS word to read fill level, busy and overflow. Single clock domain.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
//  FIFO_DEPTH    8    TX FIFO entries; power of two, 2..64
// PORTS
//  clk    in   1   system clock, rising-edge
//  rst    in   1   reset, asynchronous, active-high
//  we     in   1   processor data-memory write enable
//  addr   in   32  processor data address (byte address, word aligned)
//  wdata  in   32  processor write data
//  rdata  out  32  read data; combinational from addr
//  tx     out  1   UART serial line, idle high
//  irq    out  1   high while the FIFO is empty and the serializer is idle (all data sent)
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
//  Reset values: tx=1, FIFO empty, state IDLE, baud counter 0, overflow=0, irq=1.
//  Address map:
//   TX_DATA=32'h0000_1000  write: push wdata[7:0]
//   STATUS=32'h0000_1004   read: [0]full [1]empty [2]busy [3]overflow [15:8]count, other bits 0
//   STATUS write with wdata[3]=1 clears overflow.
//   Any other address: writes ignored, rdata=0.
//  Push rules:
//   we && addr==TX_DATA && !full -> enqueue at next edge.
//   If full -> byte dropped, overflow set (sticky). Checked against full at cycle start, even if a pop happens the same cycle.
//   A push and an overflow-clear cannot occur in the same cycle (different addresses).
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP with UART_PARITY_EN).
//   IDLE: if FIFO not empty, pop head into shift reg, go to START, clear baud counter.
//   START: tx=0. DATA: tx=shift[0], 8 bits, LSB first. STOP: tx=1.
//   Each bit state lasts exactly CLKS_PER_BIT cycles; the baud counter wraps to 0 at CLKS_PER_BIT-1.
//   STOP with FIFO non-empty: pops at its last cycle, so the next START follows with no idle gap.
//  Latency: write at edge N -> entry visible N+1 -> pop at N+1 -> tx falls after edge N+2.
//  Frame: 10*CLKS_PER_BIT cycles; 11*CLKS_PER_BIT with parity.
//  busy = state!=IDLE. count = FIFO occupancy, 0..FIFO_DEPTH.
//  irq = empty && !busy, registered.
//  Reset mid-frame: tx returns to 1 immediately (async); the partial frame and FIFO contents are discarded.
//  Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer MSB.
// CONFIGURATION
//  `UART_PARITY_EN defined: a PARITY state after DATA drives even parity (^data) for one bit period; frame is 11 bits.
//  Not defined: no PARITY state, 8N1 only. STATUS layout is unchanged either way.
// STRUCTURE
//  Package mmio_pkg:
//   TX_DATA_ADDR, STATUS_ADDR constants
//   STATUS bit-index localparams
//   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t
//  Sub-module uart_tx_fifo (params WIDTH=8, DEPTH):
//   ports push, pop, din, dout, full, empty, count; first-word-fall-through.
//  The top holds the address decode, STATUS mux, overflow flag, FSM, baud counter and shift register.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset asserted mid-frame -> tx=1 same cycle; STATUS read = 32'h0000_0002; irq=1.
//  2 Write 8'hA5 to 32'h1000 -> tx low 2 cycles later.
//     Sampled mid-bit: 0,1,0,1,0,0,1,0,1,1, then 1. Total frame 40 cycles.
//  3 Five back-to-back writes 8'h01..8'h05 -> 8'h01 popped and in flight, 8'h02..8'h05 fill the FIFO.
//     count=4, full=1, overflow=0.
//     Sixth write 8'h06 -> dropped, overflow=1.
//     The five frames go out back-to-back with no gap, 8'h06 never sent.
//  4 Write 32'h0000_0008 to 32'h1004 -> overflow=0; other STATUS bits unchanged.
//  5 Write to 32'h2000 -> no frame starts, count stays 0; read of 32'h2000 returns 0.
//  6 With `UART_PARITY_EN, send 8'h07 -> parity bit 1, frame 44 cycles.
//     Send 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, serializer state encoding and a parity helper.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit to each frame).
package mmio_pkg;

  localparam logic [31:0] TX_DATA_ADDR = 32'h0000_1000;
  localparam logic [31:0] STATUS_ADDR  = 32'h0000_1004;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor data-memory bus as seen by the UART: write strobe, address,
// write data and the combinational read data returned by the peripheral.
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// First-word-fall-through TX byte FIFO. Pointers carry one extra MSB so that
// full (same index, different lap) and empty (identical pointers) are distinct.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; storage contents are don't-care while empty, so only pointers reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Data storage write port.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX_DATA writes feed a byte FIFO that is
// serialized LSB first (8N1, or 8E1 when UART_PARITY_EN is defined) on tx.
// STATUS exposes full/empty/busy/overflow and the FIFO fill level.
// Optional feature macro: UART_PARITY_EN.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t r_state;
  uart_state_t w_next_state;

  logic [15:0]      r_baud;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic             r_tx;
  logic             r_irq;
  logic             r_overflow;
`ifdef UART_PARITY_EN
  logic             r_parity;
`endif

  logic             w_sel_tx;
  logic             w_sel_stat;
  logic             w_push;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic             w_pop;
  logic             w_tx_next;
  logic             w_bit_done;
  logic             w_busy;
  logic [7:0]       w_dout;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_status;
  logic             w_unused_wdata;

  // Address decode; a push is judged against full as it stands at cycle start.
  assign w_sel_tx   = bus.we && (bus.addr == TX_DATA_ADDR);
  assign w_sel_stat = bus.we && (bus.addr == STATUS_ADDR);
  assign w_push     = w_sel_tx && !w_full;
  assign w_ovf_set  = w_sel_tx && w_full;
  assign w_ovf_clr  = w_sel_stat && bus.wdata[STAT_OVF_BIT];

  // Only the low byte is transmitted; upper write-data bits carry no meaning.
  assign w_unused_wdata = ^bus.wdata[31:8];

  assign w_bit_done = (r_baud == BAUD_LAST);
  assign w_busy     = (r_state != IDLE);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.wdata[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: each bit state holds for one full baud period.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_next_state = START;
        end else begin
          w_next_state = IDLE;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_next_state = DATA;
        end else begin
          w_next_state = START;
        end
      end
      DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = STOP;
`endif
        end else begin
          w_next_state = DATA;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_next_state = STOP;
        end else begin
          w_next_state = PARITY;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          if (!w_empty) begin
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_state = STOP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Per-state outputs: line level for the next cycle and FIFO pop strobe.
  always_comb begin
    w_pop     = 1'b0;
    w_tx_next = 1'b1;
    case (r_state)
      IDLE: begin
        w_pop     = !w_empty;
        w_tx_next = 1'b1;
      end
      START: begin
        w_tx_next = 1'b0;
      end
      DATA: begin
        w_tx_next = r_shift[0];
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        w_tx_next = r_parity;
      end
`endif
      STOP: begin
        // Popping in the last stop cycle lets the next frame start with no gap.
        w_pop     = w_bit_done && !w_empty;
        w_tx_next = 1'b1;
      end
      default: begin
        w_pop     = 1'b0;
        w_tx_next = 1'b1;
      end
    endcase
  end

  // Baud counter, shift register and bit index; a pop always restarts the bit timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud    <= 16'd0;
      r_shift   <= 8'd0;
      r_bit_idx <= 3'd0;
`ifdef UART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_pop) begin
      r_baud    <= 16'd0;
      r_shift   <= w_dout;
      r_bit_idx <= 3'd0;
`ifdef UART_PARITY_EN
      r_parity  <= even_parity(w_dout);
`endif
    end else if (r_state == IDLE) begin
      r_baud    <= 16'd0;
    end else if (w_bit_done) begin
      r_baud <= 16'd0;
      if (r_state == DATA) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_shift   <= r_shift;
        r_bit_idx <= r_bit_idx;
      end
    end else begin
      r_baud <= r_baud + 16'd1;
    end
  end

  // Registered line driver and all-sent interrupt; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx  <= 1'b1;
      r_irq <= 1'b1;
    end else begin
      r_tx  <= w_tx_next;
      r_irq <= w_empty && !w_busy;
    end
  end

  // Sticky overflow flag; set and clear come from different addresses so never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Read mux: only STATUS returns data; every other address reads as zero.
  always_comb begin
    w_status = 32'h0000_0000;
    if (bus.addr == STATUS_ADDR) begin
      w_status[STAT_FULL_BIT]                 = w_full;
      w_status[STAT_EMPTY_BIT]                = w_empty;
      w_status[STAT_BUSY_BIT]                 = w_busy;
      w_status[STAT_OVF_BIT]                  = r_overflow;
      w_status[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(w_count);
    end else begin
      w_status = 32'h0000_0000;
    end
  end

  assign bus.rdata = w_status;
  assign tx        = r_tx;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Register-level vectors from a table, hand sequences for frame timing,
// overflow and mid-frame reset; a serial monitor decodes every frame and
// compares it with a scoreboard of bytes the bench expects on the line.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic irq;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         start_times[$];
  bit         mon_en = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic        exp_tx;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && irq === 1'b1) done = 1'b1;
    end
    check("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  // Serial monitor: decode each frame at mid-bit and compare with the scoreboard.
  initial begin
    int         ncyc;
    int         m_cnt;
    int         idx;
    bit         m_busy;
    logic [7:0] m_data;
    logic [7:0] exp_b;
    logic       m_par;
    ncyc   = 0;
    m_cnt  = 0;
    m_busy = 1'b0;
    m_data = 8'h00;
    m_par  = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst || !mon_en) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (tx === 1'b0) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          start_times.push_back(ncyc);
        end
      end else begin
        m_cnt++;
        if (m_cnt >= 2 && ((m_cnt - 2) % CPB) == 0) begin
          idx = (m_cnt - 2) / CPB;
          if (idx == 0) begin
            check("start_bit", {31'd0, tx}, 32'd0);
          end else if (idx <= 8) begin
            m_data[idx-1] = tx;
`ifdef UART_PARITY_EN
          end else if (idx == 9) begin
            m_par = tx;
`endif
          end else begin
            check("stop_bit", {31'd0, tx}, 32'd1);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got byte %h expected no frame", m_data);
            end else begin
              exp_b = exp_q.pop_front();
              check("frame_data", {24'd0, m_data}, {24'd0, exp_b});
`ifdef UART_PARITY_EN
              check("parity_bit", {31'd0, m_par}, {31'd0, ^exp_b});
`endif
            end
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic        exp_line [11];
    int          idx;

    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;

    // Register-level vectors, all applied from the idle, empty state.
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, STATUS_ADDR,   32'h0000_0002, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_2000, 32'h0000_00A5, STATUS_ADDR,   32'h0000_0002, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_2000, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{1'b1, STATUS_ADDR,   32'h0000_0008, STATUS_ADDR,   32'h0000_0002, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, TX_DATA_ADDR,  32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, STATUS_ADDR,   32'hFFFF_FFFF, STATUS_ADDR,   32'h0000_0002, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_005A, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_1008, 32'h0000_0011, 32'h0000_1008, 32'h0000_0000, 1'b1, 1'b1};

    // A5 line levels at mid-bit: start, LSB-first data, stop (or parity), then high.
    exp_line = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef UART_PARITY_EN
    exp_line[9] = 1'b0;
`endif

    // Power-on reset: outputs idle while reset is held.
    #1 rst = 1'b1;
    #2;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd1);
    rd(STATUS_ADDR, d);
    check("reset_status", d, 32'h0000_0002);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Table-driven register vectors (ignored addresses, read-as-zero, clear with nothing set).
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].addr, vecs[i].wdata);
      end else begin
        @(negedge clk);
      end
      rd(vecs[i].raddr, d);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      check($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, vecs[i].exp_tx});
    end
    // A write to an unmapped address must never start a frame.
    repeat (20) @(negedge clk);
    rd(STATUS_ADDR, d);
    check("unmapped_no_frame", d, 32'h0000_0002);

    // Single A5 frame: exact fall time, mid-bit levels and frame length via irq.
    exp_q.push_back(8'hA5);
    wr(TX_DATA_ADDR, 32'h0000_00A5);
    for (int k = 1; k <= FRAME + 4; k++) begin
      @(negedge clk);
      if (k == 1) check("a5_tx_before_fall", {31'd0, tx}, 32'd1);
      if (k == 2) check("a5_tx_fall", {31'd0, tx}, 32'd0);
      if (k >= 4 && ((k - 4) % CPB) == 0) begin
        idx = (k - 4) / CPB;
        if (idx <= 10) check($sformatf("a5_bit%0d", idx), {31'd0, tx}, {31'd0, exp_line[idx]});
      end
      if (k == FRAME + 1) check("a5_irq_busy", {31'd0, irq}, 32'd0);
      if (k == FRAME + 2) check("a5_irq_done", {31'd0, irq}, 32'd1);
    end
    wait_idle(20);

    // Five back-to-back writes fill the FIFO behind the in-flight byte; sixth overflows.
    start_times.delete();
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(8'(k));
      wr(TX_DATA_ADDR, 32'(k));
    end
    rd(STATUS_ADDR, d);
    check("fill_status", d, 32'h0000_0405);
    check("fill_irq", {31'd0, irq}, 32'd0);
    wr(TX_DATA_ADDR, 32'h0000_0006);
    rd(STATUS_ADDR, d);
    check("overflow_status", d, 32'h0000_040D);
    wr(STATUS_ADDR, 32'h0000_0008);
    rd(STATUS_ADDR, d);
    check("overflow_clear", d, 32'h0000_0405);
    wait_idle(5 * FRAME + 50);
    check("b2b_frames", start_times.size(), 32'd5);
    for (int k = 1; k < 5 && k < start_times.size(); k++) begin
      check($sformatf("b2b_gap%0d", k), start_times[k] - start_times[k-1], FRAME);
    end

    // Reset during a start bit: line snaps high immediately and the byte is lost.
    mon_en = 1'b0;
    wr(TX_DATA_ADDR, 32'h0000_003C);
    repeat (3) @(negedge clk);
    check("midframe_tx_low", {31'd0, tx}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midframe_reset_tx", {31'd0, tx}, 32'd1);
    check("midframe_reset_irq", {31'd0, irq}, 32'd1);
    rd(STATUS_ADDR, d);
    check("midframe_reset_status", d, 32'h0000_0002);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (FRAME + 10) @(negedge clk);
    rd(STATUS_ADDR, d);
    check("after_reset_status", d, 32'h0000_0002);
    check("after_reset_tx", {31'd0, tx}, 32'd1);

`ifdef UART_PARITY_EN
    // Parity frames: 07 carries parity 1, 03 carries parity 0; frame is 11 bits.
    exp_q.push_back(8'h07);
    wr(TX_DATA_ADDR, 32'h0000_0007);
    for (int k = 1; k <= FRAME + 2; k++) begin
      @(negedge clk);
      if (k == 4 + 9 * CPB) check("par07_bit", {31'd0, tx}, 32'd1);
      if (k == FRAME + 1) check("par07_irq_busy", {31'd0, irq}, 32'd0);
      if (k == FRAME + 2) check("par07_irq_done", {31'd0, irq}, 32'd1);
    end
    exp_q.push_back(8'h03);
    wr(TX_DATA_ADDR, 32'h0000_0003);
    for (int k = 1; k <= FRAME + 2; k++) begin
      @(negedge clk);
      if (k == 4 + 9 * CPB) check("par03_bit", {31'd0, tx}, 32'd0);
    end
    wait_idle(20);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
